// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_pkg;

   // Sequencer states; the order follows the normal start-up path.
   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } rst_state_e;

   // Registered output bundle, decoded from the state being entered.
   typedef struct packed {
      logic pll_rst;
      logic sys_rst_n;
      logic cpu_rst_n;
      logic ready;
   } rst_out_t;

   // Event counters stop here instead of wrapping.
   localparam logic [7:0] CNT_MAX = 8'hFF;

   // Dwell counter width: enough bits for the largest dwell, plus one spare.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

   // Saturating increment for the 8-bit event counters.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction

   // Output levels that hold while the sequencer sits in state s.
   function automatic rst_out_t state_outputs(input rst_state_e s);
      rst_out_t o;
      o.pll_rst   = (s == ST_PLL_RESET);
      o.sys_rst_n = (s == ST_RELEASE) || (s == ST_RUN);
      o.cpu_rst_n = (s == ST_RUN);
      o.ready     = (s == ST_RUN);
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   // Two back-to-back flops give metastability time to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock, then
// releases the system reset followed by the CPU reset. Loss of lock after
// release re-asserts everything and restarts the PLL.
module pll_reset_ctrl
   import pll_reset_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int RELEASE_GAP         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       cpu_rst_n,
   output logic [7:0] retry_cnt,
   output logic [7:0] lost_cnt,
   output logic       ready
);

   localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                    LOCK_STABLE_CYCLES, RELEASE_GAP);

   // Last count value of each dwell; a dwell of 1 makes this zero, so the
   // state is left on the very first edge after entry.
   localparam logic [CNT_W-1:0] PRST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);

   logic             lock_s;
   rst_state_e       state;
   logic [CNT_W-1:0] cnt;
   rst_out_t         outs;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   // Sequencer: state, shared dwell counter, event counters and registered
   // outputs all advance together so every output is a glitch-free flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_PLL_RESET;
         cnt       <= '0;
         outs      <= state_outputs(ST_PLL_RESET);
         retry_cnt <= '0;
         lost_cnt  <= '0;
      end else begin
         case (state)
            ST_PLL_RESET: begin
               if (cnt == PRST_LAST) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
                  outs  <= state_outputs(ST_WAIT_LOCK);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
                  outs  <= state_outputs(ST_STABLE);
               end else if (cnt == TIMEOUT_LAST) begin
                  state     <= ST_PLL_RESET;
                  cnt       <= '0;
                  outs      <= state_outputs(ST_PLL_RESET);
                  retry_cnt <= sat_inc8(retry_cnt);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               // A dropout before the window completes only restarts the wait;
               // it is not counted as a loss because nothing was released yet.
               if (!lock_s) begin
                  state <= ST_WAIT_LOCK;
                  cnt   <= '0;
                  outs  <= state_outputs(ST_WAIT_LOCK);
               end else if (cnt == STABLE_LAST) begin
                  state <= ST_RELEASE;
                  cnt   <= '0;
                  outs  <= state_outputs(ST_RELEASE);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               // Lock loss takes priority over completing the release gap.
               if (!lock_s) begin
                  state    <= ST_PLL_RESET;
                  cnt      <= '0;
                  outs     <= state_outputs(ST_PLL_RESET);
                  lost_cnt <= sat_inc8(lost_cnt);
               end else if (cnt == GAP_LAST) begin
                  state <= ST_RUN;
                  cnt   <= '0;
                  outs  <= state_outputs(ST_RUN);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state    <= ST_PLL_RESET;
                  cnt      <= '0;
                  outs     <= state_outputs(ST_PLL_RESET);
                  lost_cnt <= sat_inc8(lost_cnt);
               end
            end
            default: begin
               state <= ST_PLL_RESET;
               cnt   <= '0;
               outs  <= state_outputs(ST_PLL_RESET);
            end
         endcase
      end
   end

   assign pll_rst   = outs.pll_rst;
   assign sys_rst_n = outs.sys_rst_n;
   assign cpu_rst_n = outs.cpu_rst_n;
   assign ready     = outs.ready;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl with a cycle-level behavioural reference model.
module tb_pll_reset_ctrl;

   localparam int PRC     = 4;
   localparam int TO      = 32;
   localparam int STC     = 8;
   localparam int GAP     = 3;
   localparam int STARTUP = 16;

   localparam int PH_PRST = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_STAB = 2;
   localparam int PH_REL  = 3;
   localparam int PH_RUN  = 4;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       cpu_rst_n;
   logic [7:0] retry_cnt;
   logic [7:0] lost_cnt;
   logic       ready;

   pll_reset_ctrl #(
      .PLL_RST_CYCLES      (PRC),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (STC),
      .RELEASE_GAP         (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst_n  (sys_rst_n),
      .cpu_rst_n  (cpu_rst_n),
      .retry_cnt  (retry_cnt),
      .lost_cnt   (lost_cnt),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: phase, time spent in phase, lock history, event counts.
   int m_ph, m_t, m_retry, m_lost, ecnt;
   bit m_s1, m_s2;

   function automatic int next_phase(input int ph, input int t, input bit lk);
      case (ph)
         PH_PRST: return (t + 1 >= PRC) ? PH_WAIT : PH_PRST;
         PH_WAIT: return lk ? PH_STAB : ((t + 1 >= TO) ? PH_PRST : PH_WAIT);
         PH_STAB: return !lk ? PH_WAIT : ((t + 1 >= STC) ? PH_REL : PH_STAB);
         PH_REL:  return !lk ? PH_PRST : ((t + 1 >= GAP) ? PH_RUN : PH_REL);
         default: return lk ? PH_RUN : PH_PRST;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= PH_PRST; m_t <= 0; m_retry <= 0; m_lost <= 0;
         m_s1 <= 1'b0; m_s2 <= 1'b0; ecnt <= 0;
      end else begin
         m_s1 <= pll_locked;
         m_s2 <= m_s1;
         ecnt <= ecnt + 1;
         m_ph <= next_phase(m_ph, m_t, m_s2);
         m_t  <= (next_phase(m_ph, m_t, m_s2) != m_ph) ? 0 : m_t + 1;
         if (m_ph == PH_WAIT && !m_s2 && m_t + 1 >= TO && m_retry < 255)
            m_retry <= m_retry + 1;
         if ((m_ph == PH_REL || m_ph == PH_RUN) && !m_s2 && m_lost < 255)
            m_lost <= m_lost + 1;
      end
   end

   int n_cmp, n_bad;
   int sys_rise, cpu_rise, sys_fall, cpu_fall, prst_rise, prst_fall;
   int prst_rises[$];
   bit prev_prst, prev_sys, prev_cpu;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, ecnt, act, exp);
      end
   endtask

   task automatic clear_trk();
      sys_rise = -1; cpu_rise = -1; sys_fall = -1; cpu_fall = -1;
      prst_rise = -1; prst_fall = -1; prst_rises.delete();
      prev_prst = 1'b1; prev_sys = 1'b0; prev_cpu = 1'b0;
   endtask

   // One cycle: compare every output against the model, then log edges.
   task automatic tick();
      @(negedge clk);
      chk("pll_rst",   int'(pll_rst),   int'(m_ph == PH_PRST));
      chk("sys_rst_n", int'(sys_rst_n), int'(m_ph == PH_REL || m_ph == PH_RUN));
      chk("cpu_rst_n", int'(cpu_rst_n), int'(m_ph == PH_RUN));
      chk("ready",     int'(ready),     int'(m_ph == PH_RUN));
      chk("retry_cnt", int'(retry_cnt), m_retry);
      chk("lost_cnt",  int'(lost_cnt),  m_lost);
      if (pll_rst && !prev_prst) begin prst_rise = ecnt; prst_rises.push_back(ecnt); end
      if (!pll_rst && prev_prst) prst_fall = ecnt;
      if (sys_rst_n && !prev_sys && sys_rise < 0) sys_rise = ecnt;
      if (!sys_rst_n && prev_sys) sys_fall = ecnt;
      if (cpu_rst_n && !prev_cpu && cpu_rise < 0) cpu_rise = ecnt;
      if (!cpu_rst_n && prev_cpu) cpu_fall = ecnt;
      prev_prst = pll_rst; prev_sys = sys_rst_n; prev_cpu = cpu_rst_n;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      clear_trk();
   endtask

   initial begin
      int d, guard, lvl, len;
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; pll_locked = 1'b0;
      clear_trk();

      // Reset state.
      run(3);
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_sys_rst_n", int'(sys_rst_n), 0);
      chk("rst_cpu_rst_n", int'(cpu_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_retry", int'(retry_cnt), 0);
      chk("rst_lost", int'(lost_cnt), 0);

      // Clean start: lock arrives 10 cycles after release.
      do_reset();
      run(10);
      pll_locked = 1'b1;
      run(30);
      chk("clean_pll_rst_fall", prst_fall, 4);
      chk("clean_sys_rise", sys_rise, 21);
      chk("clean_cpu_rise", cpu_rise, 24);
      chk("clean_gap", cpu_rise - sys_rise, GAP);
      chk("clean_ready", int'(ready), 1);
      chk("clean_retry", int'(retry_cnt), 0);
      chk("clean_lost", int'(lost_cnt), 0);

      // Loss in RUN: resets re-assert two sync edges plus one later.
      d = ecnt;
      pll_locked = 1'b0;
      run(10);
      chk("loss_sys_fall", sys_fall, d + 3);
      chk("loss_cpu_fall", cpu_fall, d + 3);
      chk("loss_prst_rise", prst_rise, d + 3);
      chk("loss_prst_len", prst_fall - prst_rise, PRC);
      chk("loss_lost", int'(lost_cnt), 1);
      pll_locked = 1'b1;
      run(30);
      chk("loss_rerelease_ready", int'(ready), 1);
      chk("loss_rerelease_cpu", int'(cpu_rst_n), 1);

      // Minimum startup with lock already present.
      pll_locked = 1'b1;
      do_reset();
      run(25);
      chk("startup_cpu_rise", cpu_rise, STARTUP);

      // Lock drop seen on the final STABLE cycle: no release, back to waiting.
      pll_locked = 1'b1;
      do_reset();
      run(10);
      pll_locked = 1'b0;
      run(1);
      pll_locked = 1'b1;
      run(20);
      chk("laststable_sys_rise", sys_rise, 22);
      chk("laststable_lost", int'(lost_cnt), 0);

      // Glitchy lock: 5 high, 1 low, then high.
      pll_locked = 1'b0;
      do_reset();
      run(10);
      pll_locked = 1'b1;
      run(5);
      pll_locked = 1'b0;
      run(1);
      pll_locked = 1'b1;
      run(30);
      chk("glitch_sys_rise", sys_rise, 27);
      chk("glitch_lost", int'(lost_cnt), 0);
      chk("glitch_ready", int'(ready), 1);

      // Lock loss on the same edge as RELEASE->RUN: loss wins.
      pll_locked = 1'b1;
      do_reset();
      run(13);
      pll_locked = 1'b0;
      run(5);
      chk("collide_no_run", cpu_rise, -1);
      chk("collide_lost", int'(lost_cnt), 1);
      chk("collide_pll_rst", int'(pll_rst), 1);
      pll_locked = 1'b1;
      run(40);
      chk("collide_ready", int'(ready), 1);

      // Async reset mid-STABLE after a second loss.
      pll_locked = 1'b0;
      run(6);
      pll_locked = 1'b1;
      guard = 0;
      while (m_ph != PH_STAB && guard < 100) begin tick(); guard++; end
      chk("reach_stable_in_time", int'(guard < 100), 1);
      run(2);
      chk("pre_reset_lost", int'(lost_cnt), 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_pll_rst", int'(pll_rst), 1);
      chk("async_sys_rst_n", int'(sys_rst_n), 0);
      chk("async_cpu_rst_n", int'(cpu_rst_n), 0);
      chk("async_ready", int'(ready), 0);
      chk("async_lost", int'(lost_cnt), 0);
      chk("async_retry", int'(retry_cnt), 0);
      tick();
      rst_n = 1'b1;
      clear_trk();
      run(25);
      chk("async_restart_cpu_rise", cpu_rise, STARTUP);

      // Timeout retry: no lock for 100 cycles.
      pll_locked = 1'b0;
      do_reset();
      run(100);
      chk("timeout_retry", int'(retry_cnt), 2);
      chk("timeout_pulses", prst_rises.size(), 2);
      if (prst_rises.size() >= 2) begin
         chk("timeout_first_rise", prst_rises[0], PRC + TO);
         chk("timeout_period", prst_rises[1] - prst_rises[0], PRC + TO);
      end
      chk("timeout_no_release", sys_rise, -1);

      // Saturation after 300 timeouts.
      run(300 * (PRC + TO));
      chk("sat_retry", int'(retry_cnt), 255);
      chk("sat_no_release", sys_rise, -1);

      // Randomized lock activity against the model.
      do_reset();
      for (int i = 0; i < 120; i++) begin
         lvl = int'($urandom_range(0, 1));
         if (lvl == 0 && $urandom_range(0, 4) == 0) len = int'($urandom_range(30, 45));
         else len = int'($urandom_range(1, 14));
         pll_locked = lvl[0];
         run(len);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
